// File: rtl/branch_predictor_gshare.sv
// Branch direction predictor: table of saturating counters indexed by PC
// bits (bimodal) or by PC bits XOR global history (gshare). Predictions are
// registered one cycle after the request, and a sweep after reset sets
// every counter to weakly-not-taken.
// Optional build macro BP_FWD_EN: when a prediction and an update hit the
// same index in one cycle, the prediction uses the post-update counter.
//
// Handshake: pred_req and upd_valid are single-cycle strobes. They are
// accepted only while ready=1, and there is no backpressure. For every
// accepted pred_req, pred_valid is high for exactly one cycle, on the next
// cycle.
module branch_predictor_gshare #(
  parameter int BRANCH_PRED_METHOD = 1,
  parameter int ADDRESS_BITS       = 32,
  parameter int INDEX_BITS         = 4,
  parameter int GHR_BITS           = 4,
  parameter int COUNTER_BITS       = 2,
  parameter int PC_LSB             = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    ready,
  input  logic                    pred_req,
  input  logic [ADDRESS_BITS-1:0] pred_pc,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic [GHR_BITS-1:0]     pred_ghr,
  input  logic                    upd_valid,
  input  logic [ADDRESS_BITS-1:0] upd_pc,
  input  logic                    upd_taken,
  input  logic                    upd_mispredict,
  input  logic [GHR_BITS-1:0]     upd_ghr,
  output logic                    dbg_state
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] CTR_WNT = {1'b0, {(COUNTER_BITS-1){1'b1}}};
  localparam logic [COUNTER_BITS-1:0] CTR_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] CTR_MIN = '0;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_BITS-1:0]   init_ptr_q, init_ptr_d;
  logic [GHR_BITS-1:0]     ghr_q, ghr_d;
  logic                    pred_valid_q, pred_valid_d;
  logic                    pred_taken_q, pred_taken_d;
  logic [GHR_BITS-1:0]     pred_ghr_q, pred_ghr_d;
  logic [COUNTER_BITS-1:0] ctr_tbl_q [DEPTH];

  logic                    run;
  logic [INDEX_BITS-1:0]   pred_hist, upd_hist, pidx, uidx;
  logic [COUNTER_BITS-1:0] pctr, uctr, uctr_nxt;
  logic                    pred_bit;
  logic [GHR_BITS:0]       spec_shift, repair_shift;

  assign run       = (state_q == ST_RUN);
  assign ready     = run;
  assign dbg_state = state_q;

  // Init sweep walks every entry once, then stays in RUN until reset
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // History terms are zero-extended into the low index bits; bimodal mode has none
  always_comb begin
    pred_hist = '0;
    upd_hist  = '0;
    if (BRANCH_PRED_METHOD == 1) begin
      pred_hist[GHR_BITS-1:0] = ghr_q;
      upd_hist[GHR_BITS-1:0]  = upd_ghr;
    end
  end

  assign pidx = pred_pc[PC_LSB +: INDEX_BITS] ^ pred_hist;
  assign uidx = upd_pc[PC_LSB +: INDEX_BITS] ^ upd_hist;
  assign pctr = ctr_tbl_q[pidx];
  assign uctr = ctr_tbl_q[uidx];

  // Saturating increment on taken, decrement on not-taken
  always_comb begin
    uctr_nxt = uctr;
    if (upd_taken) begin
      if (uctr != CTR_MAX) uctr_nxt = uctr + 1'b1;
    end else begin
      if (uctr != CTR_MIN) uctr_nxt = uctr - 1'b1;
    end
  end

`ifdef BP_FWD_EN
  assign pred_bit = (upd_valid && (uidx == pidx)) ? uctr_nxt[COUNTER_BITS-1]
                                                  : pctr[COUNTER_BITS-1];
`else
  assign pred_bit = pctr[COUNTER_BITS-1];
`endif

  assign spec_shift   = {ghr_q, pred_bit};
  assign repair_shift = {upd_ghr, upd_taken};

  // Prediction outputs and history: a repair overrides the speculative shift
  always_comb begin
    pred_valid_d = run && pred_req;
    pred_taken_d = pred_taken_q;
    pred_ghr_d   = pred_ghr_q;
    ghr_d        = ghr_q;
    if (run && pred_req) begin
      pred_taken_d = pred_bit;
      pred_ghr_d   = (BRANCH_PRED_METHOD == 1) ? ghr_q : '0;
    end
    if (run && (BRANCH_PRED_METHOD == 1)) begin
      if (upd_valid && upd_mispredict) ghr_d = repair_shift[GHR_BITS-1:0];
      else if (pred_req)               ghr_d = spec_shift[GHR_BITS-1:0];
    end
  end

  // Control and prediction registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ghr_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_ghr_q   <= pred_ghr_d;
    end
  end

  // Counter table: the init sweep owns the write port until RUN
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT)  ctr_tbl_q[init_ptr_q] <= CTR_WNT;
    else if (upd_valid)      ctr_tbl_q[uidx]       <= uctr_nxt;
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_ghr   = pred_ghr_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare. dut_b runs in bimodal mode and
// dut_g in gshare mode. Both share the clock and the reset.
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        ready_b, pred_req_b, pred_valid_b, pred_taken_b;
  logic [31:0] pred_pc_b, upd_pc_b;
  logic [3:0]  pred_ghr_b, upd_ghr_b;
  logic        upd_valid_b, upd_taken_b, upd_mispredict_b, dbg_b;

  logic        ready_g, pred_req_g, pred_valid_g, pred_taken_g;
  logic [31:0] pred_pc_g, upd_pc_g;
  logic [3:0]  pred_ghr_g, upd_ghr_g;
  logic        upd_valid_g, upd_taken_g, upd_mispredict_g, dbg_g;

  int n_tests = 0;
  int n_fail  = 0;

  // clock
  always #5 clk = ~clk;

  branch_predictor_gshare #(.BRANCH_PRED_METHOD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .ready(ready_b),
    .pred_req(pred_req_b), .pred_pc(pred_pc_b), .pred_valid(pred_valid_b),
    .pred_taken(pred_taken_b), .pred_ghr(pred_ghr_b),
    .upd_valid(upd_valid_b), .upd_pc(upd_pc_b), .upd_taken(upd_taken_b),
    .upd_mispredict(upd_mispredict_b), .upd_ghr(upd_ghr_b), .dbg_state(dbg_b)
  );

  branch_predictor_gshare #(.BRANCH_PRED_METHOD(1)) dut_g (
    .clk(clk), .reset_n(reset_n), .ready(ready_g),
    .pred_req(pred_req_g), .pred_pc(pred_pc_g), .pred_valid(pred_valid_g),
    .pred_taken(pred_taken_g), .pred_ghr(pred_ghr_g),
    .upd_valid(upd_valid_g), .upd_pc(upd_pc_g), .upd_taken(upd_taken_g),
    .upd_mispredict(upd_mispredict_g), .upd_ghr(upd_ghr_g), .dbg_state(dbg_g)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one bimodal cycle: drive request/update, clock, leave outputs to check
  task automatic b_step(input logic req, input logic [31:0] pc,
                        input logic uv, input logic [31:0] upc, input logic ut);
    pred_req_b  = req;
    pred_pc_b   = pc;
    upd_valid_b = uv;
    upd_pc_b    = upc;
    upd_taken_b = ut;
    cyc();
    pred_req_b  = 1'b0;
    upd_valid_b = 1'b0;
  endtask

  initial begin
    logic fwd_exp;
`ifdef BP_FWD_EN
    fwd_exp = 1'b1;
`else
    fwd_exp = 1'b0;
`endif
    reset_n = 1'b0;
    pred_req_b = 0; pred_pc_b = 0; upd_valid_b = 0; upd_pc_b = 0;
    upd_taken_b = 0; upd_mispredict_b = 0; upd_ghr_b = 0;
    pred_req_g = 1; pred_pc_g = 0; upd_valid_g = 0; upd_pc_g = 0;
    upd_taken_g = 0; upd_mispredict_g = 0; upd_ghr_g = 0;

    // reset state
    cyc(); cyc();
    check("rst_ready", ready_g, 0);
    check("rst_valid", pred_valid_g, 0);
    check("rst_taken", pred_taken_g, 0);
    check("rst_ghr",   pred_ghr_g, 0);
    reset_n = 1'b1;

    // init sweep: 16 edges, requests ignored
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check($sformatf("init_ready_g_%0d", k), ready_g, (k == 16));
      check($sformatf("init_ready_b_%0d", k), ready_b, (k == 16));
      check($sformatf("init_valid_%0d", k), pred_valid_g, 0);
    end
    for (int i = 0; i < 16; i++) begin
      check($sformatf("init_ent_g_%0d", i), dut_g.ctr_tbl_q[i], 2'b01);
      check($sformatf("init_ent_b_%0d", i), dut_b.ctr_tbl_q[i], 2'b01);
    end

    // gshare: first prediction with empty history
    cyc();
    check("g_p0_valid", pred_valid_g, 1);
    check("g_p0_taken", pred_taken_g, 0);
    check("g_p0_ghr",   pred_ghr_g, 4'b0000);
    // repair with a simultaneous request: repair wins
    upd_valid_g = 1; upd_pc_g = 0; upd_ghr_g = 4'b0011;
    upd_taken_g = 1; upd_mispredict_g = 1;
    cyc();
    upd_valid_g = 0; upd_mispredict_g = 0;
    check("g_p1_ghr",   pred_ghr_g, 4'b0000);
    check("g_upd_idx3", dut_g.ctr_tbl_q[3], 2'b10);
    cyc();
    check("g_repair_ghr", pred_ghr_g, 4'b0111);
    check("g_p2_taken",   pred_taken_g, 0);
    cyc();
    check("g_spec_ghr",   pred_ghr_g, 4'b1110);
    // history 1100 with PC index 1111 lands on the trained entry 3
    pred_pc_g = 32'h3C;
    cyc();
    check("g_hist_taken", pred_taken_g, 1);
    check("g_hist_ghr",   pred_ghr_g, 4'b1100);
    pred_req_g = 0;
    cyc();
    check("g_idle_valid", pred_valid_g, 0);

    // bimodal saturation on index 4
    b_step(1, 32'h10, 0, 0, 0);
    check("b_p10_taken0", pred_taken_b, 0);
    check("b_p10_valid",  pred_valid_b, 1);
    b_step(0, 0, 1, 32'h10, 1);
    check("b_idle_valid", pred_valid_b, 0);
    b_step(0, 0, 1, 32'h10, 1);
    check("b_ent4_11", dut_b.ctr_tbl_q[4], 2'b11);
    b_step(1, 32'h10, 0, 0, 0);
    check("b_p10_taken1", pred_taken_b, 1);
    b_step(0, 0, 1, 32'h10, 1);
    check("b_ent4_sat_hi", dut_b.ctr_tbl_q[4], 2'b11);
    for (int j = 0; j < 3; j++) b_step(0, 0, 1, 32'h10, 0);
    check("b_ent4_00", dut_b.ctr_tbl_q[4], 2'b00);
    b_step(0, 0, 1, 32'h10, 0);
    check("b_ent4_sat_lo", dut_b.ctr_tbl_q[4], 2'b00);
    b_step(1, 32'h10, 0, 0, 0);
    check("b_p10_taken_lo", pred_taken_b, 0);

    // aliasing: 0x54 and 0x14 share index 5
    b_step(0, 0, 1, 32'h54, 1);
    b_step(0, 0, 1, 32'h54, 1);
    b_step(1, 32'h14, 0, 0, 0);
    check("b_alias_taken", pred_taken_b, 1);

    // same-cycle request and update on index 3
    b_step(1, 32'h0C, 1, 32'h0C, 1);
    check("b_same_taken", pred_taken_b, fwd_exp);
    check("b_same_ent3",  dut_b.ctr_tbl_q[3], 2'b10);
    b_step(1, 32'h0C, 0, 0, 0);
    check("b_after_same", pred_taken_b, 1);

    // train index 8, then reset mid-run
    b_step(0, 0, 1, 32'h20, 1);
    b_step(0, 0, 1, 32'h20, 1);
    check("b_ent8_11", dut_b.ctr_tbl_q[8], 2'b11);
    pred_req_b = 1; pred_pc_b = 32'h20;
    cyc();
    check("b_p20_taken1", pred_taken_b, 1);
    check("b_p20_valid",  pred_valid_b, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready_b", ready_b, 0);
    check("mid_rst_valid_b", pred_valid_b, 0);
    check("mid_rst_taken_b", pred_taken_b, 0);
    check("mid_rst_ready_g", ready_g, 0);
    check("mid_rst_ghr_g",   pred_ghr_g, 0);
    cyc(); cyc();
    pred_req_b = 0;
    reset_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check($sformatf("reinit_ready_%0d", k), ready_b, (k == 16));
    end
    check("reinit_ent8", dut_b.ctr_tbl_q[8], 2'b01);
    b_step(1, 32'h20, 0, 0, 0);
    check("reinit_p20_valid", pred_valid_b, 1);
    check("reinit_p20_taken", pred_taken_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
